vga_pattern_gen: RTL and testbench

Pixel-timing and test-pattern source for the VGA output path. Divides the system clock into a pixel tick, runs 640x480 horizontal/vertical counters, generates active-low sync and data-enable, and produces 4-bit-per-channel pattern colour. Its `r_internal`/`g_internal`/`b_internal` outputs feed the per-channel switch gating stage directly, and its sync outputs go straight to the VGA connector.

---
 rtl/vga_pattern_gen.sv | 168 ++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// VGA 640x480 timing generator and test-pattern source (bars, grey ramp, checkerboard, mid-grey).
// Latency: outputs describe the counter position one pixel tick old; pixel_tick is combinational.
// No backpressure: free-running raster; VGA_PATTERN_BORDER_EN adds a white one-pixel frame border.
module vga_pattern_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] mode_sel,
    output logic       pixel_tick,
    output logic       h_sync,
    output logic       v_sync,
    output logic       de,
    output logic [9:0] x_pixel,
    output logic [9:0] y_pixel,
    output logic       frame_start,
    output logic [3:0] r_internal,
    output logic [3:0] g_internal,
    output logic [3:0] b_internal
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // A one-bit divider is kept even for CLK_DIV=1 so the counter never has zero width.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
`ifdef VGA_PATTERN_BORDER_EN
    localparam logic [9:0] H_VIS_LAST = 10'(H_VISIBLE - 1);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
`endif

    localparam logic [1:0] MODE_BARS    = 2'd0;
    localparam logic [1:0] MODE_RAMP    = 2'd1;
    localparam logic [1:0] MODE_CHECKER = 2'd2;

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic [1:0]       mode_q;

    logic             frame_origin;
    logic [1:0]       mode_eff;
    logic             de_nxt;
    logic             h_sync_nxt;
    logic             v_sync_nxt;
    logic [2:0]       bar_idx;
    logic [11:0]      rgb_nxt;

    // Pixel-rate divider: wraps after CLK_DIV system clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Gated by reset so the strobe is low while reset is held, including the CLK_DIV=1 case.
    assign pixel_tick = reset_n && (div_cnt == DIV_LAST);

    // Raster position: h wraps at end of line, v steps on each h wrap and wraps at end of frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pixel_tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign frame_origin = (h_cnt == 10'd0) && (v_cnt == 10'd0);

    // The pixel at (0,0) already uses the freshly requested mode, so a frame is never split.
    assign mode_eff = frame_origin ? mode_sel : mode_q;

    // Mode is only accepted at frame origin so a mid-frame change cannot tear the picture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= '0;
        end else if (pixel_tick && frame_origin) begin
            mode_q <= mode_sel;
        end
    end

    assign de_nxt     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign h_sync_nxt = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    assign v_sync_nxt = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    assign bar_idx    = 3'(h_cnt / 10'd80);

    // Pattern colour for the current counter position; black outside the visible area.
    always_comb begin
        rgb_nxt = 12'h000;
        if (de_nxt) begin
            case (mode_eff)
                // Bar order white,yellow,cyan,green,magenta,red,blue,black is exactly
                // r=~idx[1], g=~idx[2], b=~idx[0], so no lookup table is needed.
                MODE_BARS:    rgb_nxt = {{4{~bar_idx[1]}}, {4{~bar_idx[2]}}, {4{~bar_idx[0]}}};
                MODE_RAMP:    rgb_nxt = {3{h_cnt[9:6]}};
                MODE_CHECKER: rgb_nxt = (h_cnt[5] ^ v_cnt[5]) ? 12'hFFF : 12'h000;
                default:      rgb_nxt = 12'h888;
            endcase
`ifdef VGA_PATTERN_BORDER_EN
            if ((h_cnt == 10'd0) || (h_cnt == H_VIS_LAST) ||
                (v_cnt == 10'd0) || (v_cnt == V_VIS_LAST)) begin
                rgb_nxt = 12'hFFF;
            end
`endif
        end
    end

    // Output registers load once per pixel and hold between ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_sync     <= 1'b1;
            v_sync     <= 1'b1;
            de         <= 1'b0;
            x_pixel    <= '0;
            y_pixel    <= '0;
            r_internal <= '0;
            g_internal <= '0;
            b_internal <= '0;
        end else if (pixel_tick) begin
            h_sync     <= h_sync_nxt;
            v_sync     <= v_sync_nxt;
            de         <= de_nxt;
            x_pixel    <= h_cnt;
            y_pixel    <= v_cnt;
            r_internal <= rgb_nxt[11:8];
            g_internal <= rgb_nxt[7:4];
            b_internal <= rgb_nxt[3:0];
        end
    end

    // Single-clk pulse accompanying the load of pixel (0,0).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pixel_tick && frame_origin;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen with a shortened vertical raster.
// Predictor pushes one expected pixel per predicted tick; monitor pops after each tick edge.
// Random mode_sel changes exercise frame-start latching; a mid-line reset checks restart.
module tb_vga_pattern_gen;

    localparam int CLK_DIV = 2;
    localparam int HV = 640, HFP = 16, HS = 96, HBP = 48;
    localparam int VV = 6, VFP = 2, VS = 2, VBP = 2;
    localparam int H_TOT = HV + HFP + HS + HBP;
    localparam int V_TOT = VV + VFP + VS + VBP;
    localparam int FRAME_CLK = CLK_DIV * H_TOT * V_TOT;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [11:0] rgb;
    } pix_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] mode_sel = 2'd0;
    logic       pixel_tick, h_sync, v_sync, de, frame_start;
    logic [9:0] x_pixel, y_pixel;
    logic [3:0] r_internal, g_internal, b_internal;

    vga_pattern_gen #(
        .CLK_DIV(CLK_DIV), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mode_sel(mode_sel), .pixel_tick(pixel_tick),
        .h_sync(h_sync), .v_sync(v_sync), .de(de), .x_pixel(x_pixel), .y_pixel(y_pixel),
        .frame_start(frame_start), .r_internal(r_internal), .g_internal(g_internal),
        .b_internal(b_internal)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    bit   done = 0;
    int   k = 0;
    int   cyc = 0;
    int   pushed = 0;
    int   popped = 0;
    bit   second_run = 0;
    pix_t q[$];
    pix_t rst_pix;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) k <= 0;
        else k <= k + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic finish_run();
        if (!done) begin
            done = 1;
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    endtask

    task automatic note_fail();
        errors++;
        if (errors >= 50) finish_run();
    endtask

    task automatic check_pix(input string name, input pix_t got, input pix_t exp);
        checks++;
        if (got !== exp) begin
            $display("FAIL %s got x=%0d y=%0d de=%b hs=%b vs=%b fs=%b rgb=%h want x=%0d y=%0d de=%b hs=%b vs=%b fs=%b rgb=%h",
                     name, got.x, got.y, got.de, got.hs, got.vs, got.fs, got.rgb,
                     exp.x, exp.y, exp.de, exp.hs, exp.vs, exp.fs, exp.rgb);
            note_fail();
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            $display("FAIL %s got %0d want %0d", name, got, exp);
            note_fail();
        end
    endtask

    function automatic pix_t dut_pix();
        pix_t p;
        p.x = x_pixel; p.y = y_pixel; p.de = de; p.hs = h_sync; p.vs = v_sync;
        p.fs = frame_start; p.rgb = {r_internal, g_internal, b_internal};
        return p;
    endfunction

    function automatic logic [11:0] bar_colour(input int i);
        case (i)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    // Reference pixel for the t-th tick after reset, from raster arithmetic.
    function automatic pix_t model(input int t, input int mode);
        pix_t p;
        int h, v, g;
        h = t % H_TOT;
        v = (t / H_TOT) % V_TOT;
        p.x = 10'(h); p.y = 10'(v);
        p.de = (h < HV) && (v < VV);
        p.hs = !(h >= HV + HFP && h < HV + HFP + HS);
        p.vs = !(v >= VV + VFP && v < VV + VFP + VS);
        p.fs = (h == 0) && (v == 0);
        p.rgb = 12'h000;
        if (p.de) begin
            case (mode)
                0: p.rgb = bar_colour(h / 80);
                1: begin g = h / 64; p.rgb = 12'(g * 'h111); end
                2: p.rgb = (((h / 32) + (v / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
                default: p.rgb = 12'h888;
            endcase
`ifdef VGA_PATTERN_BORDER_EN
            if (h == 0 || h == HV - 1 || v == 0 || v == VV - 1) p.rgb = 12'hFFF;
`endif
        end
        return p;
    endfunction

    // Predictor: checks the tick strobe and queues the pixel the next edge will load.
    initial begin
        int t, h, v, cur_mode;
        bit exp_tick;
        cur_mode = 0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                exp_tick = ((k + 1) % CLK_DIV) == 0;
                check_int("pixel_tick", int'(pixel_tick), int'(exp_tick));
                if (exp_tick) begin
                    t = (k + 1) / CLK_DIV - 1;
                    h = t % H_TOT;
                    v = (t / H_TOT) % V_TOT;
                    if (h == 0 && v == 0) cur_mode = int'(mode_sel);
                    q.push_back(model(t, cur_mode));
                    pushed++;
                end
            end
        end
    end

    // Monitor: after every edge, compare against the popped pixel or the held one.
    initial begin
        pix_t e, last;
        bit t;
        int frame_no, last_fs_cyc;
        logic [11:0] spot;
        last = '0; last.hs = 1'b1; last.vs = 1'b1;
        frame_no = -1;
        last_fs_cyc = -1;
        forever begin
            @(negedge clk);
            t = pixel_tick;
            @(posedge clk);
            #1;
            if (!reset_n) begin
                last = rst_pix;
                frame_no = -1;
                last_fs_cyc = -1;
            end else if (t) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL scoreboard_underflow got empty queue want pixel");
                    note_fail();
                end else begin
                    e = q.pop_front();
                    popped++;
                    check_pix("pixel", dut_pix(), e);
                    if (e.fs) begin
                        frame_no++;
                        if (last_fs_cyc >= 0) check_int("frame_period", cyc - last_fs_cyc, FRAME_CLK);
                        last_fs_cyc = cyc;
                        if (second_run) begin
`ifdef VGA_PATTERN_BORDER_EN
                            spot = 12'hFFF;
`else
                            spot = 12'h888;
`endif
                            check_int("restart_origin_rgb", int'({r_internal, g_internal, b_internal}), int'(spot));
                        end
                    end
                    if (!second_run && frame_no == 0 && e.y == 10'd1) begin
                        if (e.x == 10'd80)  check_int("bar_x80",  int'({r_internal, g_internal, b_internal}), 'hFF0);
                        if (e.x == 10'd400) check_int("bar_x400", int'({r_internal, g_internal, b_internal}), 'hF00);
                        if (e.x == 10'd639) begin
`ifdef VGA_PATTERN_BORDER_EN
                            spot = 12'hFFF;
`else
                            spot = 12'h000;
`endif
                            check_int("bar_x639", int'({r_internal, g_internal, b_internal}), int'(spot));
                        end
                        if (e.x == 10'd700) check_int("blank_x700", int'({de, r_internal, g_internal, b_internal}), 0);
                    end
                    if (!second_run && frame_no == 1 && e.y == 10'd1 && e.x == 10'd5)
                        check_int("mode3_next_frame", int'({r_internal, g_internal, b_internal}), 'h888);
                    last = e;
                    last.fs = 1'b0;
                end
            end else begin
                check_pix("hold", dut_pix(), last);
            end
        end
    end

    // Stimulus: reset, bars frame with a mid-frame switch to mode 3, random modes, mid-line reset.
    initial begin
        int elapsed, target, w;
        rst_pix = '0; rst_pix.hs = 1'b1; rst_pix.vs = 1'b1;
        reset_n = 1'b0;
        mode_sel = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_pix("reset_values", dut_pix(), rst_pix);
        check_int("reset_tick", int'(pixel_tick), 0);
        #1 reset_n = 1'b1;

        elapsed = 0;
        repeat (CLK_DIV * (3 * H_TOT + 100)) @(posedge clk);
        elapsed += CLK_DIV * (3 * H_TOT + 100);
        #2 mode_sel = 2'd3;
        repeat (FRAME_CLK + 100 - elapsed) @(posedge clk);
        elapsed = FRAME_CLK + 100;

        // Tick edges fall on posedge CLK_DIV*(t+1); stop just after x=300, y=3 of frame 2 loads.
        target = CLK_DIV * (2 * H_TOT * V_TOT + 3 * H_TOT + 300 + 1);
        while (elapsed < target) begin
            w = int'($urandom_range(50, 3000));
            if (w > target - elapsed) w = target - elapsed;
            repeat (w) @(posedge clk);
            elapsed += w;
            #2 mode_sel = 2'($urandom_range(0, 3));
        end
        check_int("pre_reset_x", int'(x_pixel), 300);
        check_int("pre_reset_y", int'(y_pixel), 3);

        reset_n = 1'b0;
        #1;
        check_pix("async_reset", dut_pix(), rst_pix);
        check_int("async_reset_tick", int'(pixel_tick), 0);
        q.delete();
        pushed = popped;
        second_run = 1;
        mode_sel = 2'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;

        repeat (CLK_DIV * (H_TOT + 50)) @(posedge clk);
        #2;
        check_int("scoreboard_drain", q.size(), 0);
        check_int("pushed_vs_popped", popped, pushed);
        finish_run();
    end

endmodule
